param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, 8, word width in bits; legal range 1..256.
REQ-003 Parameter DEPTH, 8, number of entries; power of two, range 2..1024.
REQ-004 Parameter AF_LEVEL, DEPTH-2, almost_full threshold; legal range 1..DEPTH-1.
REQ-005 Parameter AE_LEVEL, 2, almost_empty threshold; legal range 1..DEPTH-1.
REQ-006 Port clk input 1 rising-edge clock for all state.
REQ-007 Port rst input 1 synchronous active-high reset.
REQ-008 Port wr_en input 1 write request.
REQ-009 Port data_in input DATA_WIDTH write data, sampled with wr_en.
REQ-010 Port rd_en input 1 read request.
REQ-011 Port data_out output DATA_WIDTH read data, registered.
REQ-012 Port full, empty output 1 each: occupancy == DEPTH / == 0.
REQ-013 Port almost_full, almost_empty output 1 each: occupancy >= AF_LEVEL / <= AE_LEVEL.
REQ-014 Port count output $clog2(DEPTH)+1 current occupancy, 0..DEPTH.
REQ-015 Port overflow, underflow output 1 each: single-cycle pulse on a rejected write / rejected read.

Function
REQ-016 A write SHALL be accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle); data is stored at the write pointer, and the pointer advances modulo DEPTH.
REQ-017 A read SHALL be accepted when rd_en=1 and empty=0; data_out SHALL present the oldest word on the cycle after acceptance (latency 1) and hold its value otherwise.
REQ-018 When a read and a write are both accepted in one cycle, count SHALL be unchanged; when full, both SHALL be accepted.
REQ-019 When empty with rd_en=1 and wr_en=1: the write SHALL be accepted, the read rejected, and underflow pulsed; written data SHALL NOT bypass to data_out.
REQ-020 A rejected write (wr_en=1, full=1, no accepted read) SHALL leave memory, pointers and count unchanged and pulse overflow for exactly one cycle.
REQ-021 A rejected read (rd_en=1, empty=1) SHALL leave data_out unchanged and pulse underflow for exactly one cycle.
REQ-022 count, full, empty, almost_full and almost_empty SHALL be registered and SHALL reflect the occupancy after the current edge's accepted operations, with no extra lag.
REQ-023 Pointers SHALL be $clog2(DEPTH) bits and wrap naturally; full/empty SHALL be derived from count, not from pointer equality alone.
REQ-024 Data SHALL be returned in strict write order across any number of pointer wrap-arounds.

Reset
REQ-025 While rst=1, the block SHALL set both pointers and count to 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0 and data_out=0, and SHALL ignore wr_en/rd_en.
REQ-026 Reset asserted mid-operation SHALL discard all stored contents; memory array contents need not be cleared.
REQ-027 The first operation after reset SHALL be accepted on the first edge with rst=0.

Structure
REQ-028 Package fifo_pkg SHALL hold the default DATA_WIDTH/DEPTH constants and the pointer/count width helper; it SHALL NOT hold the threshold parameters.
REQ-029 Storage SHALL be a sub-module fifo_mem: simple dual-port, one write port and one registered read port, inferable as block RAM.
REQ-030 The top SHALL contain pointer, count, flag and pulse logic only; it SHALL NOT contain an explicit FSM beyond count-derived state.

Verification (DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-031 Fill: reset, then 8 writes 0x01..0x08 -> count=8, full=1, almost_full from count=6, almost_empty cleared at count=3.
REQ-032 Overflow: 9th write 0xFF while full -> overflow pulses 1 cycle, count stays 8, later reads return 0x01..0x08 only.
REQ-033 Underflow: rd_en on empty FIFO -> underflow pulses 1 cycle, data_out unchanged, count=0.
REQ-034 Concurrent: at count=8, rd_en=wr_en=1 with 0xAA -> data_out=0x01 the next cycle, count stays 8, 0xAA is read last.
REQ-035 Wrap: 20 interleaved writes/reads of an incrementing pattern keeping count between 3 and 7 -> output sequence identical to input sequence, no flag pulses.
REQ-036 Reset mid-stream: rst at count=5 -> the next cycle shows count=0, empty=1, data_out=0, and a following write/read returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg -- shared defaults and width helpers for the synchronous FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent the completely full state.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// fifo_mem -- simple dual-port storage, one write port, registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Array left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/param_sync_fifo.sv
// ============================================================================
// param_sync_fifo -- single-clock FIFO with registered count, flags and pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF_LEVEL = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE_LEVEL = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, almost_full_q, almost_empty_q;
  logic             overflow_q, underflow_q;

  logic             w_rd_acc;
  logic             w_wr_acc;

  // A read frees a slot in the same edge, so a full FIFO still takes a write.
  assign w_rd_acc = rd_en & ~empty_q;
  assign w_wr_acc = wr_en & (~full_q | w_rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (w_rd_acc) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Flags come from the next count so they carry no extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= (count_d == C_DEPTH);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= C_AF_LEVEL);
      almost_empty_q <= (count_d <= C_AE_LEVEL);
      overflow_q     <= wr_en & ~w_wr_acc;
      underflow_q    <= rd_en & empty_q;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_wr_acc & ~rst),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (w_rd_acc & ~rst),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
// ============================================================================
// tb_param_sync_fifo -- queue-model scoreboard bench for param_sync_fifo.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  param_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: plain queue of stored words plus expected read results.
  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout = '0;
  bit            mon_en   = 1'b0;
  bit            rd_fire  = 1'b0;
  bit            rst_fire = 1'b0;
  bit            exp_ovf  = 1'b0;
  bit            exp_unf  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle from a negedge; the model is advanced before the edge.
  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input bit rs);
    bit ra, wa;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    rst     = rs;
    if (rs) begin
      model.delete();
      ra = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      ra = r && (model.size() > 0);
      wa = w && ((model.size() < DEPTH) || ra);
      if (ra) exp_q.push_back(model.pop_front());
      if (wa) model.push_back(d);
      exp_ovf = w && !wa;
      exp_unf = r && !ra;
    end
    rd_fire  = ra;
    rst_fire = rs;
    mon_en   = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (rst_fire) begin
        exp_dout = '0;
      end else if (rd_fire) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: read fired with no expected word at %0t", $time);
        end else begin
          exp_dout = exp_q.pop_front();
        end
      end
      chk("data_out",     int'(data_out),     int'(exp_dout));
      chk("count",        int'(count),        model.size());
      chk("full",         int'(full),         int'(model.size() == DEPTH));
      chk("empty",        int'(empty),        int'(model.size() == 0));
      chk("almost_full",  int'(almost_full),  int'(model.size() >= AF));
      chk("almost_empty", int'(almost_empty), int'(model.size() <= AE));
      chk("overflow",     int'(overflow),     int'(exp_ovf));
      chk("underflow",    int'(underflow),    int'(exp_unf));
    end
  end

  initial begin
    logic [DW-1:0] pat;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    @(negedge clk);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);

    // Fill, overflow, concurrent op at full, then drain
    for (int i = 1; i <= 8; i++) cycle(1, 0, 8'(i), 0);
    cycle(1, 0, 8'hFF, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(1, 1, 8'hAA, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 8'h00, 0);

    // Underflow, then read+write while empty (no bypass)
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(1, 1, 8'h55, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    // Interleaved traffic through several pointer wraps
    pat = 8'h10;
    for (int i = 0; i < 5; i++) begin cycle(1, 0, pat, 0); pat++; end
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin cycle(1, 0, pat, 0); pat++; end
      else            cycle(0, 1, 8'h00, 0);
    end
    for (int i = 0; i < 10; i++) begin cycle(1, 1, pat, 0); pat++; end

    // Reset with data in flight
    cycle(1, 0, 8'h99, 1);
    cycle(0, 0, 8'h00, 0);
    cycle(1, 0, 8'h77, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    // Randomized traffic with phases biased toward full and empty
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i / 100) % 3 == 0 ? 80 : ((i / 100) % 3 == 1 ? 20 : 50);
      cycle(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp)),
            8'($urandom), ($urandom_range(127) == 0));
    end

    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
